// File: rtl/oam_dma.sv
// OAM DMA engine at 0xFF46 with private HRAM, sitting between the core and the system bus.
// Copies OAM_LEN bytes from {src_hi,8'h00} into OAM at one byte per clk; other core traffic is fenced off while it runs.
module oam_dma #(
    parameter logic [15:0] REG_ADDR = 16'hFF46,
    parameter logic [15:0] OAM_BASE = 16'hFE00,
    parameter int          OAM_LEN  = 160,
    parameter logic [15:0] HRAM_LO  = 16'hFF80,
    parameter logic [15:0] HRAM_HI  = 16'hFFFE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wd,
    input  logic        cpu_write,
    output logic [7:0]  cpu_rd,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wd,
    output logic        bus_write,
    input  logic [7:0]  bus_rd,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wd,
    output logic        oam_we,
    output logic        dma_active
);

    localparam int          HRAM_SIZE = int'(HRAM_HI) - int'(HRAM_LO) + 1;
    localparam int          HW        = (HRAM_SIZE > 1) ? $clog2(HRAM_SIZE) : 1;
    localparam logic [16:0] OAM_END   = {1'b0, OAM_BASE} + 17'(OAM_LEN);
    localparam logic [7:0]  LAST_IDX  = 8'(OAM_LEN - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_XFER  = 2'd2;

    logic [1:0]    state;
    logic [7:0]    idx;
    logic [7:0]    dma_reg;
    logic [7:0]    src_hi;
    logic [7:0]    hram [0:(1<<HW)-1];
    logic [HW-1:0] hram_idx;
    logic          hit_reg;
    logic          hit_hram;
    logic          hit_oam;
    logic          reg_wr;
    logic          in_start;
    logic          in_xfer;
    logic          fenced;
    logic [7:0]    src_map;

    always_comb begin
        hit_reg  = (cpu_addr == REG_ADDR);
        hit_hram = (cpu_addr >= HRAM_LO) && (cpu_addr <= HRAM_HI);
        hit_oam  = ({1'b0, cpu_addr} >= {1'b0, OAM_BASE}) && ({1'b0, cpu_addr} < OAM_END);
        hram_idx = HW'(cpu_addr - HRAM_LO);
        reg_wr   = cpu_write && hit_reg;
        in_start = (state == S_START);
        in_xfer  = (state == S_XFER);
        // Non-internal core accesses the engine hides from the bus this cycle.
        fenced   = in_xfer || (in_start && hit_oam);
        // Echo pages E0-FF alias down onto C0-DF work RAM.
        src_map  = (cpu_wd >= 8'hE0) ? (cpu_wd - 8'h20) : cpu_wd;
    end

    always_comb begin
        cpu_rd = bus_rd;
        if (hit_reg) begin
            cpu_rd = dma_reg;
        end else if (hit_hram) begin
            cpu_rd = hram[hram_idx];
        end else if (fenced) begin
            cpu_rd = 8'hFF;
        end
    end

    always_comb begin
        bus_wd    = cpu_wd;
        bus_addr  = cpu_addr;
        bus_write = cpu_write && !hit_reg && !hit_hram && !fenced;
        if (in_xfer) begin
            bus_addr = {src_hi, idx};
        end
        if (rst) begin
            bus_addr  = 16'h0000;
            bus_write = 1'b0;
        end
        oam_addr   = idx;
        oam_wd     = bus_rd;
        oam_we     = in_xfer && !rst;
        dma_active = (in_start || in_xfer) && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            idx     <= 8'h00;
            dma_reg <= 8'h00;
            src_hi  <= 8'h00;
        end else if (reg_wr) begin
            // A trigger always (re)starts from byte 0; any byte moved this cycle used the old page.
            dma_reg <= cpu_wd;
            src_hi  <= src_map;
            state   <= S_START;
            idx     <= 8'h00;
        end else begin
            case (state)
                S_START: begin
                    idx   <= 8'h00;
                    state <= S_XFER;
                end
                S_XFER: begin
                    if (idx == LAST_IDX) begin
                        idx   <= 8'h00;
                        state <= S_IDLE;
                    end else begin
                        idx <= idx + 8'h01;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // HRAM is deliberately left out of reset so code parked there survives.
    always_ff @(posedge clk) begin
        if (cpu_write && hit_hram) begin
            hram[hram_idx] <= cpu_wd;
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Directed and randomized bench for oam_dma against a queue-based schedule model of the DMA engine.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wd;
    logic        cpu_write;
    logic [7:0]  cpu_rd;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wd;
    logic        bus_write;
    logic [7:0]  bus_rd;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wd;
    logic        oam_we;
    logic        dma_active;

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    logic [7:0] exp_oam [0:255];
    logic [7:0] obs_oam [0:255];
    logic [7:0] snap [0:255];
    logic [7:0] hram_m [0:126];
    logic [7:0] dma_m;
    // Per-cycle schedule of the engine: -1 marks the START cycle, otherwise the source address moved that cycle.
    int q[$];

    int total  = 0;
    int passed = 0;
    int failed = 0;

    assign bus_rd = mem[bus_addr];

    oam_dma dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_wd     (cpu_wd),
        .cpu_write  (cpu_write),
        .cpu_rd     (cpu_rd),
        .bus_addr   (bus_addr),
        .bus_wd     (bus_wd),
        .bus_write  (bus_write),
        .bus_rd     (bus_rd),
        .oam_addr   (oam_addr),
        .oam_wd     (oam_wd),
        .oam_we     (oam_we),
        .dma_active (dma_active)
    );

    function automatic bit is_reg(input logic [15:0] a);
        return a == 16'hFF46;
    endfunction

    function automatic bit is_hram(input logic [15:0] a);
        return (a >= 16'hFF80) && (a <= 16'hFFFE);
    endfunction

    function automatic bit is_oam(input logic [15:0] a);
        return (a >= 16'hFE00) && (a < 16'hFEA0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [7:0] wd, input logic w);
        cpu_addr  = a;
        cpu_wd    = wd;
        cpu_write = w;
        #2;
    endtask

    // Model check of the settled cycle, model update for the coming edge, then the edge itself.
    task automatic cyc();
        bit         xfer;
        bit         start;
        bit         ewr;
        logic [7:0] erd;
        int         src;
        xfer  = (q.size() > 0) && (q[0] >= 0);
        start = (q.size() > 0) && (q[0] < 0);
        ewr   = cpu_write && !is_reg(cpu_addr) && !is_hram(cpu_addr) && !xfer
                && !(start && is_oam(cpu_addr));
        if (rst) begin
            chk("rst_active", dma_active, 0);
            chk("rst_oam_we", oam_we, 0);
            chk("rst_bus_write", bus_write, 0);
            chk("rst_bus_addr", bus_addr, 0);
        end else begin
            chk("dma_active", dma_active, q.size() > 0);
            chk("oam_we", oam_we, xfer);
            chk("bus_write", bus_write, ewr);
            if (ewr) chk("bus_wd", bus_wd, cpu_wd);
            if (xfer) begin
                chk("xfer_bus_addr", bus_addr, q[0]);
                chk("xfer_oam_addr", oam_addr, q[0] % 256);
                chk("xfer_oam_wd", oam_wd, mem[q[0]]);
            end else begin
                chk("pass_bus_addr", bus_addr, cpu_addr);
            end
            if (is_reg(cpu_addr)) erd = dma_m;
            else if (is_hram(cpu_addr)) erd = hram_m[cpu_addr - 16'hFF80];
            else if (xfer || (start && is_oam(cpu_addr))) erd = 8'hFF;
            else erd = mem[cpu_addr];
            chk("cpu_rd", cpu_rd, erd);
        end

        if (oam_we) obs_oam[oam_addr] = oam_wd;
        if (rst) begin
            q.delete();
            dma_m = 8'h00;
        end else begin
            if (xfer) exp_oam[q[0] % 256] = mem[q[0]];
            if (q.size() > 0) void'(q.pop_front());
            if (ewr) mem[cpu_addr] = cpu_wd;
            if (cpu_write && is_hram(cpu_addr)) hram_m[cpu_addr - 16'hFF80] = cpu_wd;
            if (cpu_write && is_reg(cpu_addr)) begin
                dma_m = cpu_wd;
                src = (int'(cpu_wd) >= 224) ? int'(cpu_wd) - 32 : int'(cpu_wd);
                q.delete();
                q.push_back(-1);
                for (int i = 0; i < 160; i++) q.push_back(src * 256 + i);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_drive(input bit allow_w, input bit allow_reg);
        logic [15:0] a;
        logic        w;
        int          sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0, 1:    a = 16'hFF80 + 16'($urandom_range(0, 126));
            2:       a = 16'hFE00 + 16'($urandom_range(0, 159));
            3:       a = 16'hFF46;
            4:       a = 16'hFE9F + 16'($urandom_range(0, 2));
            default: a = 16'($urandom);
        endcase
        w = allow_w && ($urandom_range(0, 3) == 0);
        if (is_reg(a) && w && !(allow_reg && ($urandom_range(0, 29) == 0))) w = 1'b0;
        drive(a, 8'($urandom), w);
    endtask

    task automatic cmp_oam(input string tag);
        for (int i = 0; i < 160; i++) chk(tag, obs_oam[i], exp_oam[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) begin
            exp_oam[i] = 8'(i) ^ 8'hA5;
            obs_oam[i] = 8'(i) ^ 8'hA5;
        end
        for (int i = 0; i < 127; i++) hram_m[i] = 8'h00;
        dma_m = 8'h00;
        rst = 1'b1;
        cpu_addr = 16'h0000;
        cpu_wd = 8'h00;
        cpu_write = 1'b0;
        @(posedge clk);
        #1;

        // Reset holds the engine quiet; register reads back as zero afterwards.
        for (int i = 0; i < 2; i++) begin
            drive(16'h1234, 8'h55, 1'b1);
            cyc();
        end
        rst = 1'b0;
        drive(16'hFF46, 8'h00, 1'b0);
        chk("t1_reg_read", cpu_rd, 8'h00);
        chk("t1_active", dma_active, 0);
        cyc();

        for (int i = 0; i < 127; i++) begin
            drive(16'hFF80 + 16'(i), 8'($urandom), 1'b1);
            cyc();
        end

        // Baseline transfer from C000 with directed core accesses mid-transfer.
        for (int i = 0; i < 160; i++) mem[16'hC000 + i] = 8'(i) ^ 8'h5A;
        drive(16'hFF46, 8'hC0, 1'b1);
        cyc();
        for (int k = 1; k <= 162; k++) begin
            case (k)
                20:      drive(16'h0150, 8'h00, 1'b0);
                21:      drive(16'h0150, 8'h77, 1'b1);
                22:      drive(16'hFF90, 8'h3C, 1'b1);
                23:      drive(16'hFF90, 8'h00, 1'b0);
                24:      drive(16'hFF46, 8'h00, 1'b0);
                default: rand_drive(1'b0, 1'b0);
            endcase
            chk("t2_active", dma_active, k <= 161);
            chk("t2_oam_we", oam_we, (k >= 2) && (k <= 161));
            if ((k >= 2) && (k <= 161)) begin
                chk("t2_bus_addr", bus_addr, 16'hC000 + k - 2);
                chk("t2_oam_addr", oam_addr, k - 2);
            end
            if (k == 20) begin
                chk("t3_blocked_read", cpu_rd, 8'hFF);
                chk("t3_read_bus_write", bus_write, 0);
            end
            if (k == 21) chk("t3_dropped_write", bus_write, 0);
            if (k == 23) chk("t3_hram_read", cpu_rd, 8'h3C);
            if (k == 24) chk("t3_reg_read", cpu_rd, 8'hC0);
            cyc();
        end
        for (int i = 0; i < 160; i++) chk("t2_oam", obs_oam[i], 8'(i) ^ 8'h5A);

        // Echo page E1 maps to C1.
        drive(16'hFF46, 8'hE1, 1'b1);
        cyc();
        for (int k = 1; k <= 162; k++) begin
            rand_drive(1'b1, 1'b0);
            if ((k >= 2) && (k <= 161)) chk("t4_bus_addr", bus_addr, 16'hC100 + k - 2);
            cyc();
        end
        cmp_oam("t4_oam");

        // Restart on the byte-80 cycle.
        drive(16'hFF46, 8'hC0, 1'b1);
        cyc();
        for (int k = 1; k <= 81; k++) begin
            rand_drive(1'b1, 1'b0);
            cyc();
        end
        drive(16'hFF46, 8'hD0, 1'b1);
        chk("t5_last_old_addr", bus_addr, 16'hC050);
        chk("t5_last_old_we", oam_we, 1);
        cyc();
        rand_drive(1'b0, 1'b0);
        chk("t5_restart_active", dma_active, 1);
        chk("t5_restart_we", oam_we, 0);
        cyc();
        for (int k = 0; k < 160; k++) begin
            rand_drive(1'b1, 1'b0);
            chk("t5_bus_addr", bus_addr, 16'hD000 + k);
            cyc();
        end
        rand_drive(1'b0, 1'b0);
        chk("t5_idle", dma_active, 0);
        cyc();
        cmp_oam("t5_oam");

        // Reset on the byte-10 cycle leaves a partial copy.
        for (int i = 0; i < 160; i++) snap[i] = obs_oam[i];
        drive(16'hFF46, 8'h40, 1'b1);
        cyc();
        for (int k = 1; k <= 11; k++) begin
            rand_drive(1'b0, 1'b0);
            cyc();
        end
        rst = 1'b1;
        drive(16'h0000, 8'h00, 1'b0);
        cyc();
        rst = 1'b0;
        drive(16'hFF46, 8'h00, 1'b0);
        chk("t6_active", dma_active, 0);
        chk("t6_oam_we", oam_we, 0);
        chk("t6_reg", cpu_rd, 8'h00);
        cyc();
        for (int i = 0; i < 160; i++)
            chk("t6_oam", obs_oam[i], (i < 10) ? mem[16'h4000 + i] : snap[i]);

        // Random traffic with occasional retriggers.
        for (int n = 0; n < 3000; n++) begin
            rand_drive(1'b1, 1'b1);
            cyc();
        end
        for (int n = 0; n < 170; n++) begin
            rand_drive(1'b0, 1'b0);
            cyc();
        end
        drive(16'h0000, 8'h00, 1'b0);
        chk("drain_idle", dma_active, 0);
        cyc();
        cmp_oam("rand_oam");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
